// File: rtl/noc_rr_merge_arbiter.sv
// rtl/noc_rr_merge_arbiter.sv - round-robin N-input merge arbiter with registered valid/ready output
// Optional packet lock holds the grant until the winner's tail flit is accepted.
module noc_rr_merge_arbiter #(
  parameter  int NUM_IN   = 3,
  parameter  int WIDTH    = 8,
  parameter  int PKT_LOCK = 1,
  localparam int SW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_last,
  output logic [NUM_IN-1:0]         in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SW-1:0]             out_src,
  input  logic                      out_ready
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]     lock_id_q, lock_id_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SW-1:0]     out_src_q, out_src_d;

  logic              found;
  logic [SW-1:0]     winner;
  logic              load_en;
  logic              accept;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return SW'(s);
  endfunction

  // Scan from the farthest offset down so the entry nearest rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    if (state_q == LOCKED) begin
      winner = lock_id_q;
      found  = in_valid[lock_id_q];
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        if (in_valid[wrap_add(rr_ptr_q, k)]) begin
          found  = 1'b1;
          winner = wrap_add(rr_ptr_q, k);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (winner == SW'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  always_comb begin
    load_en     = ~out_valid_q | out_ready;
    accept      = found & load_en & ~rst;
    in_ready    = '0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (accept) begin
      in_ready[winner] = 1'b1;
      out_valid_d      = 1'b1;
      out_data_d       = sel_data;
      out_last_d       = sel_last;
      out_src_d        = winner;
      if ((PKT_LOCK == 0) || sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = (winner == SW'(NUM_IN - 1)) ? '0 : winner + SW'(1);
      end else begin
        state_d   = LOCKED;
        lock_id_d = winner;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_noc_rr_merge_arbiter.sv
// tb/tb_noc_rr_merge_arbiter.sv - directed bench for noc_rr_merge_arbiter
// Instance a: 3 inputs, packet lock; b: 3 inputs, no lock; c: 5 inputs, packet lock.
module tb_noc_rr_merge_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  va, la, ra, vb, lb, rb;
  logic [23:0] da, db;
  logic        ova, ola, ora, ovb, olb, orb;
  logic [7:0]  oda, odb;
  logic [1:0]  osa, osb;
  logic [4:0]  vc, lc, rc;
  logic [39:0] dc;
  logic        ovc, olc, orc;
  logic [7:0]  odc;
  logic [2:0]  osc;

  int checks = 0;
  int failures = 0;

  noc_rr_merge_arbiter #(.NUM_IN(3), .WIDTH(8), .PKT_LOCK(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_data(da), .in_last(la), .in_ready(ra),
    .out_valid(ova), .out_data(oda), .out_last(ola), .out_src(osa), .out_ready(ora));

  noc_rr_merge_arbiter #(.NUM_IN(3), .WIDTH(8), .PKT_LOCK(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_data(db), .in_last(lb), .in_ready(rb),
    .out_valid(ovb), .out_data(odb), .out_last(olb), .out_src(osb), .out_ready(orb));

  noc_rr_merge_arbiter #(.NUM_IN(5), .WIDTH(8), .PKT_LOCK(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(vc), .in_data(dc), .in_last(lc), .in_ready(rc),
    .out_valid(ovc), .out_data(odc), .out_last(olc), .out_src(osc), .out_ready(orc));

  typedef struct {
    logic [2:0]  v;
    logic [23:0] d;
    logic [2:0]  l;
    logic        ordy;
    logic [2:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l,
                     input logic ordy, input logic [2:0] rdy, input logic ov,
                     input logic [7:0] od, input logic ol, input logic [1:0] os);
    vec_t e;
    e.v = v; e.d = d; e.l = l; e.ordy = ordy; e.rdy = rdy;
    e.ov = ov; e.od = od; e.ol = ol; e.os = os;
    tbl.push_back(e);
  endtask

  initial begin
    // single stream on input 2, one 4-flit packet
    add(3'b100, 24'hA0_00_00, 3'b000, 1'b1, 3'b100, 1'b1, 8'hA0, 1'b0, 2'd2);
    add(3'b100, 24'hA1_00_00, 3'b000, 1'b1, 3'b100, 1'b1, 8'hA1, 1'b0, 2'd2);
    add(3'b100, 24'hA2_00_00, 3'b000, 1'b1, 3'b100, 1'b1, 8'hA2, 1'b0, 2'd2);
    add(3'b100, 24'hA3_00_00, 3'b100, 1'b1, 3'b100, 1'b1, 8'hA3, 1'b1, 2'd2);
    add(3'b000, 24'h0,        3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0);
    // backpressure with 5C held, 6D waiting on input 1
    add(3'b011, 24'h00_6D_5C, 3'b011, 1'b0, 3'b001, 1'b1, 8'h5C, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++)
      add(3'b010, 24'h00_6D_00, 3'b010, 1'b0, 3'b000, 1'b1, 8'h5C, 1'b1, 2'd0);
    add(3'b010, 24'h00_6D_00, 3'b010, 1'b1, 3'b010, 1'b1, 8'h6D, 1'b1, 2'd1);
    add(3'b000, 24'h0,        3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0);
    // move rr_ptr to 1, then locked 3-flit packet on input 1 with a bubble
    add(3'b001, 24'h00_00_11, 3'b001, 1'b1, 3'b001, 1'b1, 8'h11, 1'b1, 2'd0);
    add(3'b111, 24'hC0_B0_20, 3'b101, 1'b1, 3'b010, 1'b1, 8'hB0, 1'b0, 2'd1);
    add(3'b111, 24'hC0_B1_20, 3'b101, 1'b1, 3'b010, 1'b1, 8'hB1, 1'b0, 2'd1);
    add(3'b101, 24'hC0_B1_20, 3'b101, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(3'b111, 24'hC0_B2_20, 3'b111, 1'b1, 3'b010, 1'b1, 8'hB2, 1'b1, 2'd1);
    add(3'b101, 24'hC0_B2_20, 3'b101, 1'b1, 3'b100, 1'b1, 8'hC0, 1'b1, 2'd2);
    add(3'b001, 24'h00_00_20, 3'b001, 1'b1, 3'b001, 1'b1, 8'h20, 1'b1, 2'd0);
    add(3'b000, 24'h0,        3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0);

    va = 3'b111; da = 24'hFF_FF_FF; la = 3'b111; ora = 1'b1;
    vb = '0; db = '0; lb = '0; orb = 1'b1;
    vc = '0; dc = '0; lc = '0; orc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ra), 64'd0);
    chk("rst_out_valid", 64'(ova), 64'd0);
    chk("rst_out_data", 64'(oda), 64'd0);
    chk("rst_out_last", 64'(ola), 64'd0);
    chk("rst_out_src", 64'(osa), 64'd0);
    va = '0; da = '0; la = '0;
    rst = 1'b0;

    foreach (tbl[n]) begin
      va = tbl[n].v; da = tbl[n].d; la = tbl[n].l; ora = tbl[n].ordy;
      #1;
      chk($sformatf("row%0d_in_ready", n), 64'(ra), 64'(tbl[n].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_out_valid", n), 64'(ova), 64'(tbl[n].ov));
      if (tbl[n].ov) begin
        chk($sformatf("row%0d_out_data", n), 64'(oda), 64'(tbl[n].od));
        chk($sformatf("row%0d_out_last", n), 64'(ola), 64'(tbl[n].ol));
        chk($sformatf("row%0d_out_src", n), 64'(osa), 64'(tbl[n].os));
      end
    end

    // reset during the 2nd flit of a 4-flit packet on input 1
    va = 3'b010; da = 24'h00_D0_00; la = 3'b000; ora = 1'b1;
    @(posedge clk); #1;
    chk("mid_flit1_src", 64'(osa), 64'd1);
    chk("mid_flit1_data", 64'(oda), 64'hD0);
    da = 24'h00_D1_00;
    @(posedge clk); #1;
    chk("mid_flit2_data", 64'(oda), 64'hD1);
    va = 3'b011; da = 24'h00_D2_E0; la = 3'b001;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(ova), 64'd0);
    chk("mid_rst_in_ready", 64'(ra), 64'd0);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(ra), 64'b001);
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(ova), 64'd1);
    chk("post_rst_src", 64'(osa), 64'd0);
    chk("post_rst_data", 64'(oda), 64'hE0);
    va = '0; da = '0; la = '0;

    // fairness without packet lock
    vb = 3'b111; db = 24'h12_11_10; lb = 3'b000;
    #1;
    chk("fair_in_ready0", 64'(rb), 64'b001);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("fair%0d_valid", k), 64'(ovb), 64'd1);
      chk($sformatf("fair%0d_src", k), 64'(osb), 64'(k % 3));
      chk($sformatf("fair%0d_data", k), 64'(odb), 64'(8'h10 + k % 3));
      chk($sformatf("fair%0d_last", k), 64'(olb), 64'd0);
      chk($sformatf("fair%0d_in_ready", k), 64'(rb), 64'(3'b001 << ((k + 1) % 3)));
    end
    vb = '0;

    // wrap-around on 5 inputs
    vc = 5'b01000; dc = 40'h00_33_00_00_00; lc = 5'b11111;
    #1;
    chk("wrap_pre_in_ready", 64'(rc), 64'b01000);
    @(posedge clk); #1;
    chk("wrap_pre_src", 64'(osc), 64'd3);
    vc = 5'b10001; dc = 40'h44_00_00_00_40;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("wrap%0d_in_ready", k), 64'(rc), (k % 2 == 0) ? 64'b10000 : 64'b00001);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_src", k), 64'(osc), (k % 2 == 0) ? 64'd4 : 64'd0);
      chk($sformatf("wrap%0d_data", k), 64'(odc), (k % 2 == 0) ? 64'h44 : 64'h40);
      chk($sformatf("wrap%0d_src_range", k), 64'(osc < 3'd5), 64'd1);
    end
    vc = '0;
    @(posedge clk); #1;
    chk("wrap_drain_valid", 64'(ovc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
